// File: rtl/puf_sequencer.sv
// puf_sequencer
//
// Challenge sequencer for a bank of delay-based PUF instances. It walks a
// programmed range of challenges. For each challenge it pulses the shared
// PUF reset, then holds run for a fixed settle window. It then samples the
// synchronized result bits and offers them to a consumer over a valid/ready
// port.
//
// Optional feature: define PUF_VOTE_EN to evaluate every challenge three
// times. The response is then the bitwise majority of the three samples,
// with a per-bit disagreement flag. Without it, a single evaluation is done
// and rsp_unstable_o is tied to 0.
//
// Ports
//   wb_clk_i        system clock (only clock)
//   wb_rst_ni       asynchronous active-low reset
//   start_i         begin a batch (sampled only in IDLE)
//   abort_i         terminate the batch, back to IDLE on the next edge
//   chal_base_i     first challenge, captured on start
//   chal_count_i    challenges in the batch, captured on start (0 = 2^CHAL_W)
//   busy_o          high in every state except IDLE
//   done_o          one-cycle pulse at normal batch completion
//   puf_reset_o     active-high reset to all PUFs
//   puf_run_o       active-high run to all PUFs
//   puf_chal_o      challenge to all PUFs (0 in IDLE)
//   puf_result_i    raw PUF result bits, asynchronous
//   rsp_valid_o     response available
//   rsp_ready_i     consumer accepts the response
//   rsp_chal_o      challenge the response belongs to
//   rsp_data_o      response bits
//   rsp_unstable_o  per-bit disagreement flag (vote builds only)
//
// state  | meaning
// IDLE   | waiting for start_i, all outputs quiet
// RESET  | puf_reset_o held for RST_CYC cycles
// RUN    | puf_run_o held for SETTLE_CYC cycles
// SAMPLE | one cycle, synchronized result captured
// OUT    | rsp_valid_o held until the consumer takes the response
// DONE   | one-cycle done_o pulse, then IDLE

module puf_sequencer #(
   parameter int N_PUF      = 4,
   parameter int CHAL_W     = 8,
   parameter int RST_CYC    = 2,
   parameter int SETTLE_CYC = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [CHAL_W-1:0] chal_base_i,
   input  logic [CHAL_W-1:0] chal_count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              puf_reset_o,
   output logic              puf_run_o,
   output logic [CHAL_W-1:0] puf_chal_o,
   input  logic [N_PUF-1:0]  puf_result_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [CHAL_W-1:0] rsp_chal_o,
   output logic [N_PUF-1:0]  rsp_data_o,
   output logic [N_PUF-1:0]  rsp_unstable_o
);

   localparam int TMR_MAX = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   // Timers count down to zero; loading N-1 gives exactly N cycles in state.
   localparam logic [TMR_W-1:0]  RST_LOAD    = TMR_W'(RST_CYC - 1);
   localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
   localparam logic [CHAL_W:0]   REM_ONE     = (CHAL_W+1)'(1);
   localparam logic [CHAL_W-1:0] CHAL_ONE    = CHAL_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_SAMPLE,
      S_OUT,
      S_DONE
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  tmr;
   // One bit wider than a challenge so a count of 0 can mean 2^CHAL_W.
   logic [CHAL_W:0]   remaining;
   logic [N_PUF-1:0]  sync1;
   logic [N_PUF-1:0]  sync2;

`ifdef PUF_VOTE_EN
   logic [1:0]        rep;
   logic [N_PUF-1:0]  samp0;
   logic [N_PUF-1:0]  samp1;
   logic [N_PUF-1:0]  unstable_q;
   logic [N_PUF-1:0]  vote_data;
   logic [N_PUF-1:0]  vote_unst;

   // The third sample is taken straight from the synchronizer.
   assign vote_data = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
   assign vote_unst = (samp0 ^ samp1) | (samp0 ^ sync2);
   assign rsp_unstable_o = unstable_q;
`else
   assign rsp_unstable_o = '0;
`endif

   // Two-flop synchronizer on the asynchronous PUF outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= puf_result_i;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= S_IDLE;
         tmr         <= '0;
         remaining   <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         puf_reset_o <= 1'b0;
         puf_run_o   <= 1'b0;
         puf_chal_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_chal_o  <= '0;
         rsp_data_o  <= '0;
`ifdef PUF_VOTE_EN
         rep         <= '0;
         samp0       <= '0;
         samp1       <= '0;
         unstable_q  <= '0;
`endif
      end else if (abort_i && (state != S_IDLE)) begin
         // Abort wins over the handshake. Any pending response is dropped.
         state       <= S_IDLE;
         tmr         <= '0;
         remaining   <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         puf_reset_o <= 1'b0;
         puf_run_o   <= 1'b0;
         puf_chal_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_chal_o  <= '0;
         rsp_data_o  <= '0;
`ifdef PUF_VOTE_EN
         rep         <= '0;
         samp0       <= '0;
         samp1       <= '0;
         unstable_q  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  state       <= S_RESET;
                  busy_o      <= 1'b1;
                  puf_reset_o <= 1'b1;
                  puf_chal_o  <= chal_base_i;
                  tmr         <= RST_LOAD;
                  if (chal_count_i == '0) begin
                     remaining <= {1'b1, {CHAL_W{1'b0}}};
                  end else begin
                     remaining <= {1'b0, chal_count_i};
                  end
`ifdef PUF_VOTE_EN
                  rep <= '0;
`endif
               end
            end

            S_RESET: begin
               if (tmr == '0) begin
                  state       <= S_RUN;
                  puf_reset_o <= 1'b0;
                  puf_run_o   <= 1'b1;
                  tmr         <= SETTLE_LOAD;
               end else begin
                  tmr <= tmr - TMR_ONE;
               end
            end

            S_RUN: begin
               if (tmr == '0) begin
                  state     <= S_SAMPLE;
                  puf_run_o <= 1'b0;
               end else begin
                  tmr <= tmr - TMR_ONE;
               end
            end

            S_SAMPLE: begin
`ifdef PUF_VOTE_EN
               if (rep != 2'd2) begin
                  // Keep this sample and go back for another evaluation.
                  if (rep == 2'd0) begin
                     samp0 <= sync2;
                  end else begin
                     samp1 <= sync2;
                  end
                  rep         <= rep + 2'd1;
                  state       <= S_RESET;
                  puf_reset_o <= 1'b1;
                  tmr         <= RST_LOAD;
               end else begin
                  state       <= S_OUT;
                  rsp_valid_o <= 1'b1;
                  rsp_chal_o  <= puf_chal_o;
                  rsp_data_o  <= vote_data;
                  unstable_q  <= vote_unst;
               end
`else
               state       <= S_OUT;
               rsp_valid_o <= 1'b1;
               rsp_chal_o  <= puf_chal_o;
               rsp_data_o  <= sync2;
`endif
            end

            S_OUT: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  if (remaining != REM_ONE) begin
                     state       <= S_RESET;
                     remaining   <= remaining - REM_ONE;
                     puf_chal_o  <= puf_chal_o + CHAL_ONE;
                     puf_reset_o <= 1'b1;
                     tmr         <= RST_LOAD;
`ifdef PUF_VOTE_EN
                     rep <= '0;
`endif
                  end else begin
                     state  <= S_DONE;
                     done_o <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               state      <= S_IDLE;
               done_o     <= 1'b0;
               busy_o     <= 1'b0;
               puf_chal_o <= '0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_sequencer.sv
module tb_puf_sequencer;

   localparam int N_PUF      = 4;
   localparam int CHAL_W     = 8;
   localparam int RST_CYC    = 2;
   localparam int SETTLE_CYC = 16;
   localparam int EVAL       = RST_CYC + SETTLE_CYC + 1;
`ifdef PUF_VOTE_EN
   localparam int NREP = 3;
`else
   localparam int NREP = 1;
`endif
   // Cycles between consecutive rsp_valid_o rises with ready held high.
   localparam int PERIOD = NREP * EVAL + 1;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_ni;
   logic              start_i;
   logic              abort_i;
   logic [CHAL_W-1:0] chal_base_i;
   logic [CHAL_W-1:0] chal_count_i;
   logic              busy_o;
   logic              done_o;
   logic              puf_reset_o;
   logic              puf_run_o;
   logic [CHAL_W-1:0] puf_chal_o;
   logic [N_PUF-1:0]  puf_result_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [CHAL_W-1:0] rsp_chal_o;
   logic [N_PUF-1:0]  rsp_data_o;
   logic [N_PUF-1:0]  rsp_unstable_o;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int cyc = 0;

   puf_sequencer #(
      .N_PUF(N_PUF), .CHAL_W(CHAL_W), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .start_i(start_i), .abort_i(abort_i),
      .chal_base_i(chal_base_i), .chal_count_i(chal_count_i),
      .busy_o(busy_o), .done_o(done_o),
      .puf_reset_o(puf_reset_o), .puf_run_o(puf_run_o), .puf_chal_o(puf_chal_o),
      .puf_result_i(puf_result_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_chal_o(rsp_chal_o), .rsp_data_o(rsp_data_o), .rsp_unstable_o(rsp_unstable_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) begin
      cyc = cyc + 1;
      if (done_o) done_cnt = done_cnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wait_valid(input int limit, output int cycles, output bit ok);
      cycles = 0;
      ok = rsp_valid_o;
      while (!ok && cycles < limit) begin
         tick();
         cycles++;
         ok = rsp_valid_o;
      end
   endtask

   task automatic wait_run(input logic level, input int limit, output bit ok);
      int n = 0;
      ok = (puf_run_o == level);
      while (!ok && n < limit) begin
         tick();
         n++;
         ok = (puf_run_o == level);
      end
   endtask

   task automatic start_batch(input logic [CHAL_W-1:0] base, input logic [CHAL_W-1:0] count);
      chal_base_i  = base;
      chal_count_i = count;
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
   endtask

   task automatic test_reset;
      bit ok;
      wb_rst_ni = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_ni = 1'b1;
      tick();
      checks++;
      if ({busy_o, done_o, puf_reset_o, puf_run_o, rsp_valid_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {busy_o, done_o, puf_reset_o, puf_run_o, rsp_valid_o});
      end
      checks++;
      if ({puf_chal_o, rsp_chal_o, rsp_data_o, rsp_unstable_o} !== 24'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 000000",
                  {puf_chal_o, rsp_chal_o, rsp_data_o, rsp_unstable_o});
      end
      puf_result_i = 4'hF;
      start_batch(8'h33, 8'd2);
      wait_run(1'b1, 10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_reach_run: got run=%b expected 1", puf_run_o);
      end
      #2 wb_rst_ni = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, puf_reset_o, puf_run_o, rsp_valid_o, puf_chal_o,
           rsp_chal_o, rsp_data_o, rsp_unstable_o} !== 29'h0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0",
                  {busy_o, done_o, puf_reset_o, puf_run_o, rsp_valid_o, puf_chal_o,
                   rsp_chal_o, rsp_data_o, rsp_unstable_o});
      end
      @(posedge wb_clk_i);
      #1 wb_rst_ni = 1'b1;
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_after: got busy=%b expected 0", busy_o);
      end
      start_batch(8'h44, 8'd1);
      checks++;
      if ({busy_o, puf_reset_o, puf_chal_o} !== {2'b11, 8'h44}) begin
         errors++;
         $display("FAIL reset_restart: got %h expected %h",
                  {busy_o, puf_reset_o, puf_chal_o}, {2'b11, 8'h44});
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      checks++;
      if ({busy_o, puf_reset_o, puf_chal_o} !== 10'h0) begin
         errors++;
         $display("FAIL reset_abort_in_reset: got %h expected 0",
                  {busy_o, puf_reset_o, puf_chal_o});
      end
   endtask

   task automatic test_single;
      int run_cnt = 0;
      int cycles;
      bit ok;
      int d0 = done_cnt;
      puf_result_i = 4'b1010;
      rsp_ready_i  = 1'b1;
      start_batch(8'h5A, 8'd1);
      // Changing the inputs after capture must not affect the batch.
      chal_base_i  = 8'h00;
      chal_count_i = 8'd5;
      checks++;
      if ({busy_o, puf_reset_o, puf_run_o, puf_chal_o} !== {3'b110, 8'h5A}) begin
         errors++;
         $display("FAIL single_edge0: got %h expected %h",
                  {busy_o, puf_reset_o, puf_run_o, puf_chal_o}, {3'b110, 8'h5A});
      end
      tick();
      checks++;
      if ({puf_reset_o, puf_run_o} !== 2'b10) begin
         errors++;
         $display("FAIL single_edge1: got %b expected 10", {puf_reset_o, puf_run_o});
      end
      tick();
      checks++;
      if ({puf_reset_o, puf_run_o} !== 2'b01) begin
         errors++;
         $display("FAIL single_edge2: got %b expected 01", {puf_reset_o, puf_run_o});
      end
      while (puf_run_o && run_cnt < 40) begin
         run_cnt++;
         tick();
      end
      checks++;
      if (run_cnt != SETTLE_CYC) begin
         errors++;
         $display("FAIL single_run_len: got %0d expected %0d", run_cnt, SETTLE_CYC);
      end
      wait_valid(NREP * EVAL + 10, cycles, ok);
      checks++;
      if (!ok || (cycles + RST_CYC + SETTLE_CYC) != NREP * EVAL) begin
         errors++;
         $display("FAIL single_valid_edge: got edge %0d (valid=%b) expected %0d",
                  cycles + RST_CYC + SETTLE_CYC, ok, NREP * EVAL);
      end
      checks++;
      if ({rsp_chal_o, rsp_data_o, rsp_unstable_o} !== {8'h5A, 4'b1010, 4'b0000}) begin
         errors++;
         $display("FAIL single_rsp: got %h expected %h",
                  {rsp_chal_o, rsp_data_o, rsp_unstable_o}, {8'h5A, 4'b1010, 4'b0000});
      end
      tick();
      checks++;
      if ({rsp_valid_o, done_o, busy_o} !== 3'b011) begin
         errors++;
         $display("FAIL single_done: got %b expected 011", {rsp_valid_o, done_o, busy_o});
      end
      tick();
      checks++;
      if ({done_o, busy_o} !== 2'b00 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL single_idle: got done=%b busy=%b pulses=%0d expected 0 0 1",
                  done_o, busy_o, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back;
      int cycles;
      bit ok;
      int t1;
      puf_result_i = 4'hA;
      rsp_ready_i  = 1'b1;
      start_batch(8'h30, 8'd2);
      wait_valid(PERIOD + 10, cycles, ok);
      t1 = cyc;
      checks++;
      if (!ok || rsp_chal_o !== 8'h30) begin
         errors++;
         $display("FAIL b2b_first: got chal=%h valid=%b expected 30 1", rsp_chal_o, ok);
      end
      tick();
      wait_valid(PERIOD + 10, cycles, ok);
      checks++;
      if (!ok || (cyc - t1) != PERIOD || rsp_chal_o !== 8'h31) begin
         errors++;
         $display("FAIL b2b_period: got period=%0d chal=%h expected %0d 31",
                  cyc - t1, rsp_chal_o, PERIOD);
      end
      tick();
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: got %b expected 1", done_o);
      end
      tick();
   endtask

   task automatic test_wrap_backpressure;
      logic [CHAL_W-1:0] exp_chal [3];
      logic [N_PUF-1:0]  pats [3];
      int cycles;
      bit ok;
      bit stable;
      int d0 = done_cnt;
      exp_chal[0] = 8'hFE; exp_chal[1] = 8'hFF; exp_chal[2] = 8'h00;
      pats[0] = 4'h3; pats[1] = 4'hC; pats[2] = 4'h6;
      rsp_ready_i  = 1'b0;
      puf_result_i = pats[0];
      start_batch(8'hFE, 8'd3);
      for (int i = 0; i < 3; i++) begin
         wait_valid(PERIOD + 10, cycles, ok);
         checks++;
         if (!ok || rsp_chal_o !== exp_chal[i] || rsp_data_o !== pats[i] ||
             puf_chal_o !== exp_chal[i]) begin
            errors++;
            $display("FAIL wrap_rsp%0d: got valid=%b chal=%h data=%h puf_chal=%h expected 1 %h %h %h",
                     i, ok, rsp_chal_o, rsp_data_o, puf_chal_o, exp_chal[i], pats[i], exp_chal[i]);
         end
         stable = 1'b1;
         repeat (10) begin
            tick();
            if (!rsp_valid_o || rsp_chal_o !== exp_chal[i] || rsp_data_o !== pats[i])
               stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL wrap_stall%0d: got unstable response expected held %h/%h",
                     i, exp_chal[i], pats[i]);
         end
         rsp_ready_i = 1'b1;
         tick();
         rsp_ready_i = 1'b0;
         if (i < 2) puf_result_i = pats[i + 1];
         checks++;
         if (rsp_valid_o !== 1'b0 || done_o !== (i == 2)) begin
            errors++;
            $display("FAIL wrap_after%0d: got valid=%b done=%b expected 0 %0d",
                     i, rsp_valid_o, done_o, (i == 2));
         end
      end
      tick();
      tick();
      checks++;
      if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done_count: got pulses=%0d busy=%b expected 1 0",
                  done_cnt - d0, busy_o);
      end
   endtask

   task automatic test_abort;
      int cycles;
      bit ok;
      int d0 = done_cnt;
      rsp_ready_i  = 1'b0;
      puf_result_i = 4'h5;
      start_batch(8'h10, 8'd4);
      wait_valid(PERIOD + 10, cycles, ok);
      checks++;
      if (!ok || rsp_chal_o !== 8'h10) begin
         errors++;
         $display("FAIL abort_first: got chal=%h valid=%b expected 10 1", rsp_chal_o, ok);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      wait_valid(PERIOD + 10, cycles, ok);
      checks++;
      if (!ok || rsp_chal_o !== 8'h11 || rsp_data_o !== 4'h5) begin
         errors++;
         $display("FAIL abort_second: got chal=%h data=%h valid=%b expected 11 5 1",
                  rsp_chal_o, rsp_data_o, ok);
      end
      abort_i     = 1'b1;
      rsp_ready_i = 1'b1;
      tick();
      abort_i     = 1'b0;
      rsp_ready_i = 1'b0;
      checks++;
      if ({busy_o, done_o, rsp_valid_o, puf_reset_o, puf_run_o, puf_chal_o,
           rsp_chal_o, rsp_data_o} !== 25'h0) begin
         errors++;
         $display("FAIL abort_outputs: got %h expected 0",
                  {busy_o, done_o, rsp_valid_o, puf_reset_o, puf_run_o, puf_chal_o,
                   rsp_chal_o, rsp_data_o});
      end
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      checks++;
      if ({busy_o, puf_reset_o} !== 2'b00) begin
         errors++;
         $display("FAIL abort_start_ignored: got %b expected 00", {busy_o, puf_reset_o});
      end
      repeat (5) tick();
      checks++;
      if (done_cnt - d0 != 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got pulses=%0d busy=%b expected 0 0",
                  done_cnt - d0, busy_o);
      end
   endtask

   task automatic test_count_zero;
      int cycles;
      bit ok;
      logic [CHAL_W-1:0] exp;
      rsp_ready_i  = 1'b1;
      puf_result_i = 4'h9;
      start_batch(8'h00, 8'd0);
      for (int i = 0; i < 256; i++) begin
         exp = i[CHAL_W-1:0];
         wait_valid(PERIOD + 10, cycles, ok);
         checks++;
         if (!ok || rsp_chal_o !== exp || rsp_data_o !== 4'h9) begin
            errors++;
            $display("FAIL count0_rsp%0d: got valid=%b chal=%h data=%h expected 1 %h 9",
                     i, ok, rsp_chal_o, rsp_data_o, exp);
         end
         tick();
         if (i < 255) begin
            checks++;
            if (done_o !== 1'b0) begin
               errors++;
               $display("FAIL count0_early_done%0d: got 1 expected 0", i);
            end
         end
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL count0_done: got %b expected 1", done_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL count0_idle: got busy=%b expected 0", busy_o);
      end
   endtask

`ifdef PUF_VOTE_EN
   task automatic test_vote;
      int cycles;
      bit ok;
      bit ok_all = 1'b1;
      logic [N_PUF-1:0] seq [3];
      seq[0] = 4'b0001; seq[1] = 4'b0000; seq[2] = 4'b0001;
      rsp_ready_i  = 1'b0;
      puf_result_i = seq[0];
      start_batch(8'h77, 8'd1);
      for (int e = 0; e < 3; e++) begin
         wait_run(1'b1, 2 * EVAL, ok);
         ok_all &= ok;
         wait_run(1'b0, 2 * EVAL, ok);
         ok_all &= ok;
         if (e < 2) puf_result_i = seq[e + 1];
      end
      wait_valid(EVAL, cycles, ok);
      checks++;
      if (!ok || !ok_all || rsp_data_o !== 4'b0001 || rsp_unstable_o !== 4'b0001) begin
         errors++;
         $display("FAIL vote_majority: got valid=%b data=%b unstable=%b expected 1 0001 0001",
                  ok, rsp_data_o, rsp_unstable_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      tick();
   endtask
`endif

   initial begin
      wb_rst_ni    = 1'b0;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      chal_base_i  = '0;
      chal_count_i = '0;
      puf_result_i = '0;
      rsp_ready_i  = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap_backpressure();
      test_abort();
      test_count_zero();
`ifdef PUF_VOTE_EN
      test_vote();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
